// File: rtl/periph_bus_if.sv
// Register bus between a host and periph_bus: transfer strobes, word address,
// write data and the one-cycle read response.
interface periph_bus_if;
    logic        write_i;
    logic        read_i;
    logic [3:0]  addr_i;
    logic [31:0] value_i;
    logic [31:0] rdata_o;
    logic        rvalid_o;

    modport master (output write_i, read_i, addr_i, value_i, input rdata_o, rvalid_o);
    modport slave  (input write_i, read_i, addr_i, value_i, output rdata_o, rvalid_o);
endinterface

// File: rtl/periph_bus.sv
// Small peripheral block: LED register, scratch and cycle counter registers,
// and a FIFO-fed 8N1 UART transmitter behind a single-cycle register bus.
module periph_bus #(
    parameter int FREQ       = 27000000,
    parameter int BAUD       = 115200,
    parameter int LED_W      = 6,
    parameter int FIFO_DEPTH = 16
) (
    input  logic             clk_i,
    input  logic             rstn_i,
    periph_bus_if.slave      bus,
    output logic [LED_W-1:0] led_o,
    output logic             uart_tx_o
);
    localparam int CLKS  = FREQ / BAUD;
    localparam int CNT_W = $clog2(CLKS);
    localparam int AW    = $clog2(FIFO_DEPTH);
    localparam int CW    = AW + 1;

    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(CLKS - 1);
    localparam logic [CW-1:0]    COUNT_MAX = CW'(FIFO_DEPTH);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_START = 2'd1;
    localparam logic [1:0] ST_DATA  = 2'd2;
    localparam logic [1:0] ST_STOP  = 2'd3;

    localparam logic [3:0] A_LED     = 4'd0;
    localparam logic [3:0] A_TXDATA  = 4'd1;
    localparam logic [3:0] A_STATUS  = 4'd2;
    localparam logic [3:0] A_CYCLES  = 4'd3;
    localparam logic [3:0] A_SCRATCH = 4'd4;

    logic [LED_W-1:0] led_q, led_d;
    logic [31:0]      scratch_q, scratch_d;
    logic [31:0]      cycles_q, cycles_d;
    logic             ovf_q, ovf_d;
    logic [31:0]      rdata_q, rdata_d;
    logic             rvalid_q, rvalid_d;
    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       bit_q, bit_d;
    logic [7:0]       shift_q, shift_d;
    logic             tx_q, tx_d;
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;

    logic [7:0] fifo_mem [FIFO_DEPTH];

    logic        fifo_empty, fifo_full, pop, push_req, push_ok, ovf_event;
    logic [31:0] status, led_rd, rd_mux;

    always_comb begin
        fifo_empty = (count_q == '0);
        fifo_full  = (count_q == COUNT_MAX);
        pop        = (state_q == ST_IDLE) && !fifo_empty;
        push_req   = bus.write_i && (bus.addr_i == A_TXDATA);
        // A pop in the same cycle frees the slot, so a full FIFO still accepts.
        push_ok    = push_req && (!fifo_full || pop);
        ovf_event  = push_req && fifo_full && !pop;

        status          = '0;
        status[0]       = (state_q != ST_IDLE);
        status[1]       = fifo_empty;
        status[2]       = fifo_full;
        status[3]       = ovf_q;
        status[8 +: CW] = count_q;

        led_rd             = '0;
        led_rd[LED_W-1:0]  = led_q;

        case (bus.addr_i)
            A_LED:     rd_mux = led_rd;
            A_STATUS:  rd_mux = status;
            A_CYCLES:  rd_mux = cycles_q;
            A_SCRATCH: rd_mux = scratch_q;
            default:   rd_mux = '0;
        endcase
    end

    always_comb begin
        rvalid_d  = bus.read_i;
        rdata_d   = bus.read_i ? rd_mux : rdata_q;
        led_d     = (bus.write_i && bus.addr_i == A_LED) ? bus.value_i[LED_W-1:0] : led_q;
        scratch_d = (bus.write_i && bus.addr_i == A_SCRATCH) ? bus.value_i : scratch_q;
        cycles_d  = (bus.write_i && bus.addr_i == A_CYCLES) ? '0 : cycles_q + 32'd1;
        ovf_d     = ovf_event ? 1'b1
                  : ((bus.read_i && bus.addr_i == A_STATUS) ? 1'b0 : ovf_q);

        wr_ptr_d = push_ok ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d = pop ? rd_ptr_q + AW'(1) : rd_ptr_q;
        case ({push_ok, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        case (state_q)
            ST_IDLE: begin
                if (pop) begin
                    shift_d = fifo_mem[rd_ptr_q];
                    cnt_d   = '0;
                    state_d = ST_START;
                end
            end
            ST_START: begin
                if (cnt_q == CNT_LAST) begin
                    cnt_d   = '0;
                    bit_d   = '0;
                    state_d = ST_DATA;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_DATA: begin
                if (cnt_q == CNT_LAST) begin
                    cnt_d   = '0;
                    shift_d = {1'b0, shift_q[7:1]};
                    if (bit_q == 3'd7) begin
                        state_d = ST_STOP;
                    end else begin
                        bit_d = bit_q + 3'd1;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_STOP: begin
                if (cnt_q == CNT_LAST) begin
                    cnt_d   = '0;
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase
        // Line level follows the state being entered, so the output flop changes on the same edge.
        if (state_d == ST_START) begin
            tx_d = 1'b0;
        end else if (state_d == ST_DATA) begin
            tx_d = shift_d[0];
        end else begin
            tx_d = 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (push_ok && rstn_i) begin
            fifo_mem[wr_ptr_q] <= bus.value_i[7:0];
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            led_q     <= '0;
            scratch_q <= '0;
            cycles_q  <= '0;
            ovf_q     <= 1'b0;
            rdata_q   <= '0;
            rvalid_q  <= 1'b0;
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            bit_q     <= '0;
            shift_q   <= '0;
            tx_q      <= 1'b1;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
        end else begin
            led_q     <= led_d;
            scratch_q <= scratch_d;
            cycles_q  <= cycles_d;
            ovf_q     <= ovf_d;
            rdata_q   <= rdata_d;
            rvalid_q  <= rvalid_d;
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bit_q     <= bit_d;
            shift_q   <= shift_d;
            tx_q      <= tx_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
        end
    end

    assign bus.rdata_o  = rdata_q;
    assign bus.rvalid_o = rvalid_q;
    assign led_o        = led_q;
    assign uart_tx_o    = tx_q;
endmodule
